// File: rtl/pc_ops_pkg.sv
// pc_ops_pkg
// Opcode encodings for the PC/stack unit. The CPU control unit shares these
// encodings. Codes 3'b110 and 3'b111 are reserved, and the PC unit treats
// them as HOLD.
package pc_ops_pkg;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_LOAD   = 3'b010,
        OP_BRANCH = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101
    } pc_op_e;

endpackage : pc_ops_pkg

// File: rtl/ras_lifo.sv
// ras_lifo
// Return-address stack (LIFO). A write goes to index count, and a read comes
// from index count-1. The full and empty guards are applied here, so a push
// when full and a pop when empty are both ignored. Only the count is reset.
// The storage array is not reset.
// Ports:
//   clk    rising-edge clock
//   clr    asynchronous active-low reset (clears count only)
//   push   write din on top of the stack (ignored when full)
//   pop    discard the top entry (ignored when empty)
//   din    data to push
//   dout   current top entry (combinational read at count-1)
//   count  number of valid entries, 0..DEPTH
//   full   count == DEPTH
//   empty  count == 0
module ras_lifo
    import pc_ops_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_m1;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == {CW{1'b0}});
    assign w_do_push  = push & ~w_full;
    assign w_do_pop   = pop & ~w_empty & ~push;
    assign w_count_m1 = r_count - CW'(1);
    // When not full, count < DEPTH, so its low bits are a valid write slot.
    assign w_wr_idx   = r_count[AW-1:0];
    // When count is 0 this index wraps, but a pop is blocked in that case.
    assign w_rd_idx   = w_count_m1[AW-1:0];

    assign dout  = r_mem[w_rd_idx];
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

    // Entry count tracks the accepted pushes and pops.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_count <= {CW{1'b0}};
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= w_count_m1;
        end else begin
            r_count <= r_count;
        end
    end

    // The storage array is written only on an accepted push and is never reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule : ras_lifo

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
// Program counter with sequential increment, load, relative branch and
// call/return through a return-address stack. One operation executes per
// rising edge of clk.
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset (Q=RESET_PC, stack emptied, flags 0)
//   op         operation (see pc_ops_pkg; 110/111 act as HOLD)
//   cond       branch condition, used only by BRANCH
//   D          load/call target, or signed branch offset
//   flag_clr   synchronous clear of ovf/unf (a flag set on the same edge wins)
//   Q          registered PC
//   ras_count  valid stack entries
//   ras_full   ras_count == DEPTH
//   ras_empty  ras_count == 0
//   ovf        sticky: CALL attempted while the stack was full
//   unf        sticky: RET attempted while the stack was empty
module pc_stack_unit
    import pc_ops_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               INC      = 4,
    parameter int               DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [2:0]             op,
    input  logic                   cond,
    input  logic [WIDTH-1:0]       D,
    input  logic                   flag_clr,
    output logic [WIDTH-1:0]       Q,
    output logic [$clog2(DEPTH):0] ras_count,
    output logic                   ras_full,
    output logic                   ras_empty,
    output logic                   ovf,
    output logic                   unf
);

    logic [WIDTH-1:0] r_pc;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_full;
    logic             w_empty;
    logic             w_is_call;
    logic             w_is_ret;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_seq_pc  = r_pc + WIDTH'(INC);
    assign w_is_call = (op == OP_CALL);
    assign w_is_ret  = (op == OP_RET);
    assign w_ovf_set = w_is_call & w_full;
    assign w_unf_set = w_is_ret & w_empty;

    // The return address is always the sequential successor of the calling PC.
    ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .clr   (clr),
        .push  (w_is_call),
        .pop   (w_is_ret),
        .din   (w_seq_pc),
        .dout  (w_ras_top),
        .count (ras_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Select the next PC. This single mux feeds r_pc.
    always_comb begin
        w_next_pc = r_pc;
        case (op)
            OP_HOLD:   w_next_pc = r_pc;
            OP_INC:    w_next_pc = w_seq_pc;
            OP_LOAD:   w_next_pc = D;
            OP_BRANCH: begin
                if (cond) begin
                    w_next_pc = r_pc + D;
                end else begin
                    w_next_pc = w_seq_pc;
                end
            end
            OP_CALL:   w_next_pc = D;
            OP_RET: begin
                // A RET on an empty stack falls through to the next instruction.
                if (w_empty) begin
                    w_next_pc = w_seq_pc;
                end else begin
                    w_next_pc = w_ras_top;
                end
            end
            default:   w_next_pc = r_pc;
        endcase
    end

    // Update the PC register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Sticky error flags. A set on the same edge takes priority over flag_clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~flag_clr);
            r_unf <= w_unf_set | (r_unf & ~flag_clr);
        end
    end

    assign Q         = r_pc;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign ras_full  = w_full;
    assign ras_empty = w_empty;

endmodule : pc_stack_unit

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter WIDTH, default 32, PC and data width in bits.
REQ-002 Parameter INC, default 4, sequential increment step.
REQ-003 Parameter DEPTH, default 8, return-address stack entries; a power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-low.
REQ-007 op  input  3  operation: 000 HOLD, 001 INC, 010 LOAD, 011 BRANCH, 100 CALL, 101 RET, 110/111 treated as HOLD.
REQ-008 cond  input  1  branch condition, sampled only when op is BRANCH.
REQ-009 D  input  WIDTH  load target (LOAD, CALL) or signed two's-complement offset (BRANCH).
REQ-010 flag_clr  input  1  synchronous clear of the sticky error flags.
REQ-011 Q  output  WIDTH  current PC, registered.
REQ-012 ras_count  output  clog2(DEPTH)+1  number of valid stack entries.
REQ-013 ras_full / ras_empty  output  1 each  ras_count equals DEPTH / ras_count equals 0.
REQ-014 ovf / unf  output  1 each  sticky push-overflow and pop-underflow flags.

Function
REQ-015 One operation executes per clock edge; Q shows the result one cycle after op is sampled, with no other latency.
REQ-016 HOLD: Q, the stack and the flags are unchanged.
REQ-017 INC: Q becomes Q+INC, modulo 2^WIDTH.
REQ-018 LOAD: Q becomes D.
REQ-019 BRANCH with cond=1: Q becomes Q+D, modulo 2^WIDTH. BRANCH with cond=0: Q becomes Q+INC.
REQ-020 CALL, stack not full: Q+INC (modulo 2^WIDTH) is pushed, ras_count increments, and Q becomes D.
REQ-021 CALL, stack full: no push, ras_count is unchanged, ovf is set, and Q still becomes D.
REQ-022 RET, stack not empty: Q becomes the top entry and ras_count decrements.
REQ-023 RET, stack empty: ovf and the stack are unchanged, unf is set, and Q becomes Q+INC.
REQ-024 ras_full and ras_empty are combinational decodes of ras_count and are valid in the same cycle.
REQ-025 flag_clr=1 clears ovf and unf on the edge. If an error occurs on the same edge, that error's flag is set, because set wins over clear.
REQ-026 A PC equal to 2^WIDTH-INC followed by INC wraps to 0 with no flag.
REQ-027 Stack storage is LIFO: entries are written at index ras_count and read from index ras_count-1. Stack contents are not reset; only the count is.

Reset
REQ-028 When clr=0, the block immediately and asynchronously sets Q=RESET_PC, ras_count=0, ovf=0 and unf=0, independent of clk.
REQ-029 Reset asserted mid-call-sequence discards all stack entries. The first RET after release sets unf.
REQ-030 After clr rises, the first active edge executes op normally.

Structure
REQ-031 The opcode encodings (HOLD through RET) live in a shared package with the CPU control unit, named pc_ops_pkg.
REQ-032 The return-address stack is one sub-module, ras_lifo, parameterised by WIDTH and DEPTH. It has push, pop, din, dout and count ports, and both full and empty guards are applied inside it.
REQ-033 PC next-value selection is a single combinational mux in pc_stack_unit that feeds one register.

Verification
REQ-034 Reset, then INC x3 -> Q=0, 4, 8, 12. Then assert clr=0 between edges -> Q=0 before the next edge.
REQ-035 At Q=0x100: BRANCH with D=0xFFFFFFF0, cond=1 -> Q=0xF0. Then BRANCH cond=0 -> Q=0xF4.
REQ-036 At Q=0x40: CALL D=0x200, then CALL D=0x300, then RET, then RET -> Q=0x200, 0x300, 0x204, 0x44. ras_count goes 1, 2, 1, 0.
REQ-037 Issue 9 CALLs with DEPTH=8 -> ras_full=1 after the 8th call. The 9th call sets ovf=1, leaves ras_count=8, and still loads Q.
REQ-038 RET on an empty stack at Q=0x10 -> Q=0x14, unf=1. flag_clr together with another empty RET -> unf stays 1. flag_clr alone -> unf=0.
REQ-039 Load Q=0xFFFFFFFC, then INC -> Q=0x00000000 and no flag changes.
